// File: rtl/bf_session_ctrl.sv
// Host-side session sequencer for the byte-stream Brainfuck core: loads a framed
// program plus NUL terminator, starts the core, routes runtime I/O and reports completion.
module bf_session_ctrl #(
    parameter int unsigned TIMEOUT_W    = 20,
    parameter int unsigned ABORT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [7:0]  host_data,
    input  logic        host_valid,
    output logic        host_ready,
    output logic [7:0]  res_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        done,
    output logic        timeout,
    output logic [15:0] out_count,
    output logic        busy,
    output logic [7:0]  core_in_data,
    output logic        core_in_valid,
    input  logic        core_in_ack,
    input  logic [7:0]  core_out_data,
    input  logic        core_out_valid,
    output logic        core_out_ack,
    output logic        core_start,
    input  logic        core_ready,
    output logic        core_nrst
);

    localparam int unsigned ABT_W = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;
    localparam logic [ABT_W-1:0] ABT_LAST = ABT_W'(ABORT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_NUL,
        S_START,
        S_RUN,
        S_ABORT
    } state_t;

    state_t               r_state;
    logic [7:0]           r_len;
    logic [7:0]           r_cnt;
    logic [TIMEOUT_W-1:0] r_wdog;
    logic [15:0]          r_out_count;
    logic [ABT_W-1:0]     r_abt;
    logic                 r_done;
    logic                 r_timeout;
    logic                 r_start;

    logic       w_host_ready;
    logic       w_core_in_valid;
    logic [7:0] w_core_in_data;
    logic       w_res_valid;
    logic [7:0] w_res_data;
    logic       w_core_out_ack;
    logic       w_host_xfer;
    logic       w_core_in_xfer;
    logic       w_res_xfer;
    logic [7:0] w_cnt_inc;

    // Channel routing is purely combinational so the host sees the core with no added latency.
    always_comb begin
        w_host_ready    = 1'b0;
        w_core_in_valid = 1'b0;
        w_core_in_data  = 8'h00;
        w_res_valid     = 1'b0;
        w_res_data      = 8'h00;
        w_core_out_ack  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_host_ready = core_ready;
            end
            S_LOAD: begin
                w_core_in_valid = host_valid;
                w_core_in_data  = host_data;
                w_host_ready    = core_in_ack;
            end
            S_NUL: begin
                w_core_in_valid = 1'b1;
            end
            S_RUN: begin
                w_core_in_valid = host_valid;
                w_core_in_data  = host_data;
                w_host_ready    = core_in_ack;
                w_res_valid     = core_out_valid;
                w_res_data      = core_out_data;
                w_core_out_ack  = res_ready;
            end
            default: begin
            end
        endcase
    end

    assign w_host_xfer    = host_valid & w_host_ready;
    assign w_core_in_xfer = w_core_in_valid & core_in_ack;
    assign w_res_xfer     = w_res_valid & res_ready;
    assign w_cnt_inc      = r_cnt + 8'd1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_wdog      <= '0;
            r_out_count <= '0;
            r_abt       <= '0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_start     <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_start   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_host_xfer) begin
                        r_len       <= host_data;
                        r_cnt       <= '0;
                        r_out_count <= '0;
                        r_state     <= (host_data == 8'h00) ? S_NUL : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_core_in_xfer) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == r_len) begin
                            r_state <= S_NUL;
                        end
                    end
                end
                S_NUL: begin
                    if (core_in_ack) begin
                        r_start <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_wdog  <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_wdog <= r_wdog + 1'b1;
                    if (w_res_xfer && (r_out_count != '1)) begin
                        r_out_count <= r_out_count + 16'd1;
                    end
                    // Completion takes priority over a watchdog expiring in the same cycle.
                    if (core_ready) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (r_wdog == '1) begin
                        r_abt   <= '0;
                        r_state <= S_ABORT;
                    end
                end
                S_ABORT: begin
                    if (r_abt == ABT_LAST) begin
                        r_abt     <= '0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_abt <= r_abt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign host_ready    = w_host_ready;
    assign res_data      = w_res_data;
    assign res_valid     = w_res_valid;
    assign core_in_data  = w_core_in_data;
    assign core_in_valid = w_core_in_valid;
    assign core_out_ack  = w_core_out_ack;
    assign core_start    = r_start;
    assign done          = r_done;
    assign timeout       = r_timeout;
    assign out_count     = r_out_count;
    assign busy          = (r_state != S_IDLE);
    assign core_nrst     = nrst & (r_state != S_ABORT);

endmodule

// File: tb/tb_bf_session_ctrl.sv
// Scoreboard bench for bf_session_ctrl with a behavioural Brainfuck core stand-in and
// an untimed reference interpreter supplying the expected loads, outputs and completions.
module tb_bf_session_ctrl;

    typedef logic [7:0] u8;
    typedef struct packed {
        logic        to;
        logic [15:0] cnt;
    } done_t;

    localparam int unsigned TW = 12;
    localparam int unsigned AC = 2;
    localparam int STEP_LIMIT = 1200;
    localparam int WAIT_LIMIT = 20000;

    logic        clk;
    logic        nrst;
    logic [7:0]  host_data;
    logic        host_valid;
    logic        host_ready;
    logic [7:0]  res_data;
    logic        res_valid;
    logic        res_ready;
    logic        done;
    logic        timeout;
    logic [15:0] out_count;
    logic        busy;
    logic [7:0]  core_in_data;
    logic        core_in_valid;
    logic        core_in_ack;
    logic [7:0]  core_out_data;
    logic        core_out_valid;
    logic        core_out_ack;
    logic        core_start;
    logic        core_ready;
    logic        core_nrst;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int rr_stall = 0;

    u8     prog[$];
    u8     inp[$];
    u8     ref_out[$];
    u8     exp_out[$];
    u8     exp_load[$];
    done_t exp_done[$];
    int    ref_reads;
    bit    ref_halted;

    bf_session_ctrl #(.TIMEOUT_W(TW), .ABORT_CYCLES(AC)) dut (
        .clk(clk), .nrst(nrst),
        .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .done(done), .timeout(timeout), .out_count(out_count), .busy(busy),
        .core_in_data(core_in_data), .core_in_valid(core_in_valid), .core_in_ack(core_in_ack),
        .core_out_data(core_out_data), .core_out_valid(core_out_valid), .core_out_ack(core_out_ack),
        .core_start(core_start), .core_ready(core_ready), .core_nrst(core_nrst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stand-in: accepts text while idle, runs one instruction per cycle after start.
    u8    c_text[256];
    u8    c_tape[256];
    logic c_run;
    u8    c_pc;
    u8    c_ptr;
    u8    c_addr;
    u8    c_op;

    assign c_op           = c_text[c_pc];
    assign core_ready     = ~c_run;
    assign core_in_ack    = core_in_valid & (~c_run | (c_op == 8'h2C));
    assign core_out_valid = c_run & (c_op == 8'h2E);
    assign core_out_data  = c_tape[c_ptr];

    function automatic u8 match_fwd(input u8 p);
        int d = 0;
        for (int i = int'(p); i < 256; i++) begin
            if (c_text[i] == 8'h5B) d++;
            else if (c_text[i] == 8'h5D) begin
                d--;
                if (d == 0) return u8'(i);
            end
        end
        return p;
    endfunction

    function automatic u8 match_bwd(input u8 p);
        int d = 0;
        for (int i = int'(p); i >= 0; i--) begin
            if (c_text[i] == 8'h5D) d++;
            else if (c_text[i] == 8'h5B) begin
                d--;
                if (d == 0) return u8'(i);
            end
        end
        return p;
    endfunction

    always @(posedge clk or negedge core_nrst) begin
        if (!core_nrst) begin
            c_run  <= 1'b0;
            c_pc   <= 8'h00;
            c_ptr  <= 8'h00;
            c_addr <= 8'h00;
        end else if (!c_run) begin
            if (core_in_valid && core_in_ack) begin
                c_text[c_addr] <= core_in_data;
                c_addr         <= c_addr + 8'd1;
            end
            if (core_start) begin
                c_run  <= 1'b1;
                c_pc   <= 8'h00;
                c_ptr  <= 8'h00;
                c_addr <= 8'h00;
                for (int i = 0; i < 256; i++) c_tape[i] <= 8'h00;
            end
        end else begin
            case (c_op)
                8'h2B: begin c_tape[c_ptr] <= c_tape[c_ptr] + 8'd1; c_pc <= c_pc + 8'd1; end
                8'h2D: begin c_tape[c_ptr] <= c_tape[c_ptr] - 8'd1; c_pc <= c_pc + 8'd1; end
                8'h3E: begin c_ptr <= c_ptr + 8'd1; c_pc <= c_pc + 8'd1; end
                8'h3C: begin c_ptr <= c_ptr - 8'd1; c_pc <= c_pc + 8'd1; end
                8'h2E: if (core_out_ack) c_pc <= c_pc + 8'd1;
                8'h2C: if (core_in_valid) begin c_tape[c_ptr] <= core_in_data; c_pc <= c_pc + 8'd1; end
                8'h5B: c_pc <= (c_tape[c_ptr] == 8'h00) ? match_fwd(c_pc) + 8'd1 : c_pc + 8'd1;
                8'h5D: c_pc <= (c_tape[c_ptr] != 8'h00) ? match_bwd(c_pc) + 8'd1 : c_pc + 8'd1;
                8'h00: c_run <= 1'b0;
                default: c_pc <= c_pc + 8'd1;
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic fail_stop(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no DUT response within %0d cycles", name, WAIT_LIMIT);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Untimed reference: program semantics only, with a step cap to classify runaway programs.
    task automatic run_ref();
        u8  tape[256];
        int pc = 0, ptr = 0, ip = 0, steps = 0, d;
        bit starve = 0;
        ref_out.delete();
        ref_halted = 0;
        for (int i = 0; i < 256; i++) tape[i] = 8'h00;
        while (!ref_halted && !starve && steps < STEP_LIMIT) begin
            if (pc >= prog.size()) ref_halted = 1;
            else begin
                steps++;
                case (prog[pc])
                    8'h2B: tape[ptr] = tape[ptr] + 8'd1;
                    8'h2D: tape[ptr] = tape[ptr] - 8'd1;
                    8'h3E: ptr = (ptr + 1) % 256;
                    8'h3C: ptr = (ptr + 255) % 256;
                    8'h2E: ref_out.push_back(tape[ptr]);
                    8'h2C: if (ip < inp.size()) begin tape[ptr] = inp[ip]; ip++; end else starve = 1;
                    8'h5B: if (tape[ptr] == 8'h00) begin
                        d = 1;
                        while (d != 0) begin
                            pc++;
                            if (prog[pc] == 8'h5B) d++;
                            else if (prog[pc] == 8'h5D) d--;
                        end
                    end
                    8'h5D: if (tape[ptr] != 8'h00) begin
                        d = 1;
                        while (d != 0) begin
                            pc--;
                            if (prog[pc] == 8'h5D) d++;
                            else if (prog[pc] == 8'h5B) d--;
                        end
                    end
                    default: ;
                endcase
                pc++;
            end
        end
        ref_reads = ip;
    endtask

    task automatic add_str(input string s);
        for (int i = 0; i < s.len(); i++) prog.push_back(u8'(s[i]));
    endtask

    task automatic load_prog(input string s);
        prog.delete();
        inp.delete();
        add_str(s);
    endtask

    task automatic send_byte(input u8 b);
        int g;
        int k = 0;
        g = $urandom_range(0, 2);
        repeat (g) begin @(posedge clk); #1; end
        host_data  = b;
        host_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (host_ready) break;
            k++;
            if (k > WAIT_LIMIT) fail_stop("host_ready_wait");
        end
        @(posedge clk);
        #1;
        host_valid = 1'b0;
        host_data  = 8'h00;
    endtask

    task automatic start_session();
        done_t d;
        run_ref();
        foreach (prog[i]) exp_load.push_back(prog[i]);
        exp_load.push_back(8'h00);
        if (ref_halted) foreach (ref_out[i]) exp_out.push_back(ref_out[i]);
        d.to  = ~ref_halted;
        d.cnt = ref_halted ? 16'(ref_out.size()) : 16'h0000;
        exp_done.push_back(d);
        send_byte(u8'(prog.size()));
        foreach (prog[i]) send_byte(prog[i]);
        for (int i = 0; i < ref_reads; i++) send_byte(inp[i]);
    endtask

    task automatic wait_done();
        int start = done_cnt;
        int k = 0;
        while (done_cnt == start) begin
            @(posedge clk);
            k++;
            if (k > WAIT_LIMIT) fail_stop("done_wait");
        end
        #1;
    endtask

    task automatic run_session();
        start_session();
        wait_done();
    endtask

    task automatic gen_random();
        int n;
        for (int tries = 0; tries < 50; tries++) begin
            prog.delete();
            inp.delete();
            n = $urandom_range(1, 14);
            for (int t = 0; t < n; t++) begin
                case ($urandom_range(0, 8))
                    0: add_str("+");
                    1: add_str("-");
                    2: add_str(">");
                    3: add_str("<");
                    4: add_str(".");
                    5: add_str(",");
                    6: add_str("[-]");
                    7: add_str("+[.-]");
                    default: add_str("++++");
                endcase
            end
            for (int i = 0; i < 32; i++) inp.push_back(u8'($urandom_range(0, 255)));
            run_ref();
            if (ref_halted) return;
        end
        load_prog("+.");
    endtask

    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            res_ready = ($urandom_range(0, 99) >= rr_stall);
        end
    end

    // Monitor: every DUT-presented transfer or pulse is matched against the scoreboard queues.
    int    abt_len    = 0;
    bit    prev_stall = 0;
    bit    prev_start = 0;
    u8     prev_data;
    done_t mon_d;
    u8     mon_e;

    always @(negedge clk) begin
        if (!nrst) begin
            abt_len    = 0;
            prev_stall = 0;
            prev_start = 0;
        end else begin
            if (prev_stall) begin
                chk("res_hold_valid", int'(res_valid), 1);
                chk("res_hold_data", int'(res_data), int'(prev_data));
            end
            prev_stall = res_valid & ~res_ready;
            prev_data  = res_data;

            if (res_valid && res_ready) begin
                if (exp_out.size() == 0) chk("res_unexpected", 1, 0);
                else begin
                    mon_e = exp_out.pop_front();
                    chk("res_data", int'(res_data), int'(mon_e));
                end
            end

            if (core_in_valid && core_in_ack && !c_run) begin
                if (exp_load.size() == 0) chk("load_unexpected", 1, 0);
                else begin
                    mon_e = exp_load.pop_front();
                    chk("load_byte", int'(core_in_data), int'(mon_e));
                end
            end

            if (core_start) begin
                chk("start_single_cycle", int'(prev_start), 0);
                chk("start_after_full_load", exp_load.size(), 0);
            end
            prev_start = core_start;

            if (done) begin
                done_cnt++;
                if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    mon_d = exp_done.pop_front();
                    chk("done_timeout", int'(timeout), int'(mon_d.to));
                    chk("done_out_count", int'(out_count), int'(mon_d.cnt));
                    chk("done_busy_low", int'(busy), 0);
                end
            end
            if (timeout) chk("timeout_with_done", int'(done), 1);

            if (!core_nrst) abt_len++;
            else if (abt_len != 0) begin
                chk("abort_len", abt_len, int'(AC));
                abt_len = 0;
            end
        end
    end

    initial begin
        int start;
        nrst       = 1'b0;
        host_valid = 1'b0;
        host_data  = 8'h00;
        @(negedge clk);
        chk("rst_core_nrst_low", int'(core_nrst), 0);
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_core_start", int'(core_start), 0);
        chk("rst_core_in_valid", int'(core_in_valid), 0);
        chk("rst_core_out_ack", int'(core_out_ack), 0);
        chk("rst_core_nrst", int'(core_nrst), 1);
        chk("rst_host_ready", int'(host_ready), 1);
        @(posedge clk);
        #1;

        load_prog("+.");
        run_session();

        load_prog(",.");
        inp.push_back(8'h41);
        rr_stall = 100;
        start_session();
        start = 0;
        while (!res_valid && start < 1000) begin @(negedge clk); start++; end
        chk("stall_res_valid_seen", int'(res_valid), 1);
        repeat (5) @(posedge clk);
        #1;
        rr_stall = 0;
        wait_done();

        load_prog("");
        run_session();

        load_prog("+[]");
        run_session();
        load_prog("+.");
        run_session();

        load_prog("+++++");
        send_byte(8'd5);
        for (int i = 0; i < 3; i++) begin
            exp_load.push_back(prog[i]);
            send_byte(prog[i]);
        end
        nrst  = 1'b0;
        start = done_cnt;
        @(negedge clk);
        chk("midrst_core_nrst", int'(core_nrst), 0);
        chk("midrst_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_idle", int'(busy), 0);
        chk("midrst_no_done", done_cnt, start);
        chk("midrst_load_drained", exp_load.size(), 0);
        @(posedge clk);
        #1;
        load_prog("+.");
        run_session();

        rr_stall = 30;
        load_prog("+[.+]");
        run_session();

        prog.delete();
        inp.delete();
        for (int i = 0; i < 254; i++) prog.push_back(($urandom_range(0, 3) == 0) ? 8'h3E : 8'h2B);
        prog.push_back(8'h2E);
        run_session();

        for (int s = 0; s < 20; s++) begin
            rr_stall = $urandom_range(0, 50);
            gen_random();
            run_session();
        end

        repeat (5) @(posedge clk);
        chk("exp_out_drained", exp_out.size(), 0);
        chk("exp_load_drained", exp_load.size(), 0);
        chk("exp_done_drained", exp_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
